// File: rtl/glove_pkg.sv
// Shared types and constants for the glove UART frame parser.
// Frame: SYNC0 SYNC1 LEN payload[LEN] CSUM.
package glove_pkg;

  localparam int N_CH_DEFAULT = 8;
  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;
  localparam int FRAME_LEN = 2 * N_CH_DEFAULT;

  typedef enum logic [2:0] {
    HUNT0,
    HUNT1,
    LEN,
    PAYLOAD,
    CSUM
  } parser_state_t;

  typedef logic [15:0] sample_t;

  function automatic sample_t sat_inc(input sample_t v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/glove_byte_timeout.sv
// Inter-byte idle watchdog: counts idle cycles while enabled,
// expires on the TIMEOUT-th idle cycle and restarts from zero.
module glove_byte_timeout #(
  parameter int TIMEOUT = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Expiry ignores i_clr so a byte racing the deadline is dropped.
  assign o_expire = i_en && (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!i_en || i_clr || o_expire) cnt_d = '0;
    else cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/glove_frame_parser.sv
// Parses the glove UART byte stream into checksummed sample frames
// and commits all channels atomically on each good frame.
module glove_frame_parser #(
  parameter int         N_CH    = glove_pkg::N_CH_DEFAULT,
  parameter logic [7:0] SYNC0   = glove_pkg::SYNC0,
  parameter logic [7:0] SYNC1   = glove_pkg::SYNC1,
  parameter int         TIMEOUT = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [16*N_CH-1:0] o_ch_data,
  output logic               o_frame_valid,
  output logic [15:0]        o_frame_cnt,
  output logic [15:0]        o_err_cnt,
  output logic               o_busy
);

  import glove_pkg::*;

  localparam int LB = 2 * N_CH;
  localparam int IW = $clog2(LB);
  localparam int DW = 16 * N_CH;

  parser_state_t state_q, state_d;
  logic [DW-1:0] stage_q, stage_d;
  logic [DW-1:0] ch_q, ch_d;
  logic [7:0]    acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          fv_q, fv_d;
  sample_t       fcnt_q, fcnt_d;
  sample_t       ecnt_q, ecnt_d;
  logic          to_en, to_expire;

  assign to_en = (state_q == LEN) || (state_q == PAYLOAD)
              || (state_q == CSUM);

  glove_byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (to_en),
    .i_clr    (i_rx_valid),
    .o_expire (to_expire)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    fv_d    = 1'b0;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    if (to_expire) begin
      state_d = HUNT0;
      ecnt_d  = sat_inc(ecnt_q);
    end else if (i_rx_valid) begin
      unique case (state_q)
        HUNT0: if (i_rx_data == SYNC0) state_d = HUNT1;
        HUNT1: begin
          if (i_rx_data == SYNC1) state_d = LEN;
          else if (i_rx_data != SYNC0) state_d = HUNT0;
        end
        LEN: begin
          if (i_rx_data == 8'(LB)) begin
            state_d = PAYLOAD;
            acc_d   = i_rx_data;
            idx_d   = '0;
          end else begin
            state_d = HUNT0;
            ecnt_d  = sat_inc(ecnt_q);
          end
        end
        PAYLOAD: begin
          stage_d[{idx_q, 3'b000} +: 8] = i_rx_data;
          acc_d = acc_q + i_rx_data;
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(LB - 1)) state_d = CSUM;
        end
        CSUM: begin
          state_d = HUNT0;
          if (i_rx_data == acc_q) begin
            ch_d   = stage_q;
            fcnt_d = fcnt_q + 16'd1;
            fv_d   = 1'b1;
          end else begin
            ecnt_d = sat_inc(ecnt_q);
          end
        end
        default: state_d = HUNT0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= HUNT0;
      stage_q <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      fv_q    <= 1'b0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      fv_q    <= fv_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign o_ch_data     = ch_q;
  assign o_frame_valid = fv_q;
  assign o_frame_cnt   = fcnt_q;
  assign o_err_cnt     = ecnt_q;
  assign o_busy        = (state_q != HUNT0);

endmodule
